imem_bank: RTL
==============

Name: imem_bank

Overview:
- Parametrised instruction memory for the single-cycle core, with a fetch port and a logic-analyzer (LA) load/readback port.
- Replaces the fixed 16-entry hard-coded program store. Memory contents are initialised by a post-reset sequencer rather than a reset branch.
- Adds fetch handshake, alignment and range fault detection, and runtime re-initialisation.
- Decodes the fetched word into opcode, register fields, a one-hot instruction type and a sign-extended immediate for the control path.

Parameters:
- XLEN, 32, width of pc and immediate.
- DEPTH, 16, number of 32-bit words; power of two, minimum 4.
- ADDR_W, $clog2(DEPTH), word-index width; localparam, not overridable.

Ports:
- clk  in  1  core clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  fetch request for pc this cycle.
- pc  in  XLEN  byte address of the instruction.
- fetch_ready  out  1  bank accepts fetches (state RUN).
- fetch_valid  out  1  fetch response valid this cycle.
- fetch_fault  out  1  response pc was misaligned or out of range.
- instr  out  32  fetched word.
- instruction_type  out  6  one-hot {j,u,b,s,i,r}.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- immediate  out  XLEN  sign-extended immediate.
- la_wr_valid  in  1  LA write request.
- la_wr_ready  out  1  LA write accepted when high together with la_wr_valid.
- la_addr  in  ADDR_W  LA word index, used for write and readback.
- la_wdata  in  32  LA write data.
- la_rd_data  out  32  registered readback of mem[la_addr].
- la_reinit  in  1  pulse that reruns the init sequence.
- busy  out  1  high in state INIT.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values: state=INIT, init_idx=0, fetch_valid=0, fetch_fault=0, instr=0x00000013, la_rd_data=0. The memory array itself is not reset.
- FSM INIT:
  - One write per cycle at init_idx.
  - Entries 0..DEPTH-2 receive NOP 0x00000013.
  - Entry DEPTH-1 receives jal x0 with offset -(DEPTH-1)*4, which jumps back to 0. For DEPTH=16 this word is 0xFC5FF06F.
  - After writing DEPTH-1, transition to RUN. INIT lasts exactly DEPTH cycles after rst deassertion.
  - busy=1, fetch_ready=0, la_wr_ready=0.
- FSM RUN:
  - busy=0, fetch_ready=1, la_wr_ready=1.
  - la_reinit=1 moves to INIT next cycle with init_idx=0.
- Fetch:
  - fetch_req & fetch_ready at cycle N gives fetch_valid=1 at cycle N+1, with instr = mem[pc>>2].
  - fault = (pc[1:0]!=0) | (pc[XLEN-1:2] >= DEPTH).
  - On fault: fetch_fault=1, fetch_valid=1, instr=0x00000013.
  - A fetch_req while not ready is ignored: no response, fetch_valid=0.
  - instr holds its value when there is no fetch.
- LA write: when la_wr_valid & la_wr_ready, mem[la_addr] <= la_wdata.
- Same-cycle collision between a write and a fetch/readback of the same address: read-before-write, so the fetch or readback returns the old word.
- la_rd_data <= mem[la_addr] every cycle in RUN; it holds during INIT.
- la_reinit in the same cycle as an accepted fetch: the fetch completes with pre-init data; fetch_ready drops the next cycle.
- rst asserted mid-INIT or mid-RUN: immediate return to INIT with init_idx=0; a pending response is dropped (fetch_valid=0).
- Decode (combinational from instr):
  - r: opcode 0110011.
  - i: 0010011, 0000011, 1100111, 1110011.
  - s: 0100011.
  - b: 1100011.
  - u: 0110111, 0010111.
  - j: 1101111.
  - Any other opcode gives type 0.
- Immediate: standard RV32 I/S/B/U/J formats, sign-extended to XLEN. Type r or unknown gives 0. The full XLEN width is driven (no 1-bit truncation).

Decomposition:
- Shared package imem_pkg:
  - Opcode constants.
  - Instruction-type one-hot typedef and bit indices.
  - NOP constant 0x00000013.
  - Function building the jal-to-zero word from DEPTH.
- Sub-module imem_decode: purely combinational field, type and immediate decode. It is reused by the future pipelined core.

Test Plan:
- Reset, then wait DEPTH=16 cycles; busy falls at cycle 16. Fetch pc=0x3C -> instr=0xFC5FF06F, type=100000, immediate=0xFFFFFFC4. Fetch pc=0x0 -> 0x00000013, immediate=0.
- LA write addr 1 = 0x0000A023 (sw x0,0(x1)), then fetch pc=4 -> type=000100, rs2=0, rs1=1, immediate=0. Same-cycle write of 0x03C00093 to addr 2 with fetch pc=8 -> old NOP returned; the next fetch returns 0x03C00093 with immediate=60.
- Fetch pc=0x6 -> fetch_fault=1, instr=0x00000013. Fetch pc=0x40 -> fetch_fault=1. Fetch pc=0x3C -> fault=0.
- Write B-type 0x00208463 (beq x1,x2,8) to addr 3 and fetch -> type=001000, immediate=8. Write 0xFE000EE3 (beq x0,x0,-4) -> immediate=0xFFFFFFFC.
- Pulse la_reinit in RUN -> busy=1 for 16 cycles and fetch_req ignored (fetch_valid=0). After that, the words at addrs 1 to 3 read back as NOP.
- Assert rst at init_idx=7 -> busy stays 1, and the full 16-cycle INIT restarts after rst falls.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants, types and helpers for the instruction memory bank
// and its decoder.
package imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef logic [5:0] itype_t;

  localparam int IT_R = 0;
  localparam int IT_I = 1;
  localparam int IT_S = 2;
  localparam int IT_B = 3;
  localparam int IT_U = 4;
  localparam int IT_J = 5;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // jal x0 back to word 0 from the last word of a depth-entry store
  function automatic logic [31:0] jal_to_zero(int depth);
    logic [20:0] off;
    off = 21'(-(depth - 1) * 4);
    return {off[20], off[10:1], off[11],
            off[19:12], 5'd0, OP_JAL};
  endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch, decode and logic-analyzer signals of the instruction bank.
// The bank uses the slave modport, its driver the master modport.
interface imem_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              fetch_req;
  logic [XLEN-1:0]   pc;
  logic              fetch_ready;
  logic              fetch_valid;
  logic              fetch_fault;
  logic [31:0]       instr;
  logic [5:0]        instruction_type;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   immediate;
  logic              la_wr_valid;
  logic              la_wr_ready;
  logic [ADDR_W-1:0] la_addr;
  logic [31:0]       la_wdata;
  logic [31:0]       la_rd_data;
  logic              la_reinit;
  logic              busy;

  modport master (
    output fetch_req, pc, la_wr_valid,
           la_addr, la_wdata, la_reinit,
    input  fetch_ready, fetch_valid,
           fetch_fault, instr,
           instruction_type, opcode, rd,
           rs1, rs2, funct3, funct7,
           immediate, la_wr_ready,
           la_rd_data, busy
  );

  modport slave (
    input  fetch_req, pc, la_wr_valid,
           la_addr, la_wdata, la_reinit,
    output fetch_ready, fetch_valid,
           fetch_fault, instr,
           instruction_type, opcode, rd,
           rs1, rs2, funct3, funct7,
           immediate, la_wr_ready,
           la_rd_data, busy
  );

endinterface

// File: rtl/imem_decode.sv
// Combinational RV32 field, format and immediate decode of one
// instruction word.
module imem_decode
  import imem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output itype_t          itype,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin
    itype = '0;
    unique case (instr[6:0])
      OP_R:     itype[IT_R] = 1'b1;
      OP_IMM,
      OP_LOAD,
      OP_JALR,
      OP_SYS:   itype[IT_I] = 1'b1;
      OP_STORE: itype[IT_S] = 1'b1;
      OP_BR:    itype[IT_B] = 1'b1;
      OP_LUI,
      OP_AUIPC: itype[IT_U] = 1'b1;
      OP_JAL:   itype[IT_J] = 1'b1;
      default:  itype = '0;
    endcase
  end

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      itype[IT_I]:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      itype[IT_S]:
        imm32 = {{20{instr[31]}},
                 instr[31:25], instr[11:7]};
      itype[IT_B]:
        imm32 = {{19{instr[31]}}, instr[31],
                 instr[7], instr[30:25],
                 instr[11:8], 1'b0};
      itype[IT_U]:
        imm32 = {instr[31:12], 12'h000};
      itype[IT_J]:
        imm32 = {{11{instr[31]}}, instr[31],
                 instr[19:12], instr[20],
                 instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imem_bank.sv
// Instruction memory bank: self-initialising program store with a
// fetch port, fault detection and a logic-analyzer load port.
module imem_bank
  import imem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input logic   clk,
  input logic   rst,
  imem_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [31:0] JAL0 = jal_to_zero(DEPTH);

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       la_rd_q, la_rd_d;

  logic              run;
  logic              fetch_go;
  logic              pc_bad;
  logic [ADDR_W-1:0] fetch_idx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign run       = state_q == ST_RUN;
  assign fetch_go  = bus.fetch_req & run;
  assign fetch_idx = bus.pc[ADDR_W+1:2];
  assign pc_bad    =
    (bus.pc[1:0] != 2'b00) |
    (bus.pc[XLEN-1:2] >= (XLEN-2)'(DEPTH));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = fetch_go;
    fault_d   = fetch_go & pc_bad;
    instr_d   = instr_q;
    la_rd_d   = la_rd_q;
    mem_we    = 1'b0;
    mem_waddr = bus.la_addr;
    mem_wdata = bus.la_wdata;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = (idx_q == LAST) ? JAL0 : NOP;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we  = bus.la_wr_valid;
        la_rd_d = mem[bus.la_addr];
        if (bus.la_reinit) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    // memory reads see the pre-write word on a same-cycle collision
    if (fetch_go)
      instr_d = pc_bad ? NOP : mem[fetch_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= NOP;
      la_rd_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
      la_rd_q <= la_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  itype_t          dec_type;
  logic [6:0]      dec_opcode;
  logic [4:0]      dec_rd;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [2:0]      dec_funct3;
  logic [6:0]      dec_funct7;
  logic [XLEN-1:0] dec_imm;

  imem_decode #(.XLEN(XLEN)) u_decode (
    .instr  (instr_q),
    .itype  (dec_type),
    .opcode (dec_opcode),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .funct3 (dec_funct3),
    .funct7 (dec_funct7),
    .imm    (dec_imm)
  );

  assign bus.fetch_ready      = run;
  assign bus.la_wr_ready      = run;
  assign bus.busy             = ~run;
  assign bus.fetch_valid      = valid_q;
  assign bus.fetch_fault      = fault_q;
  assign bus.instr            = instr_q;
  assign bus.la_rd_data       = la_rd_q;
  assign bus.instruction_type = dec_type;
  assign bus.opcode           = dec_opcode;
  assign bus.rd               = dec_rd;
  assign bus.rs1              = dec_rs1;
  assign bus.rs2              = dec_rs2;
  assign bus.funct3           = dec_funct3;
  assign bus.funct7           = dec_funct7;
  assign bus.immediate        = dec_imm;

endmodule
